uart_rx_controller: RTL and testbench

Sequencing and buffering controller for the UART receive path. It drives the receiver's enable and resynchronises the receiver's level-held status outputs into the system clock domain. Each completed frame is turned into exactly one push into an 8-byte first-word-fall-through FIFO, read by the consumer through a valid/ready handshake. It also keeps framing-error and parity-error counters and a sticky overrun flag for the register block.

---
 rtl/uart_rx_controller.sv | 215 +++++++++++++++++++++
 tb/tb_uart_rx_controller.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_controller.sv
// -----------------------------------------------------------------------------
// uart_rx_controller
//
// Sequencing and buffering controller for the UART receive path. It enables
// the receiver while running, brings the receiver's level-held status signals
// into the clk domain, and turns each completed frame into one push into a
// small first-word-fall-through FIFO. The FIFO is read by a consumer through a
// valid/ready handshake. The block also keeps saturating framing and parity
// error counters and a sticky overrun flag for the register block.
//
// Ports
//   clk, reset            system clock (posedge); async active-high reset
//   ctrl_enable           software receive enable
//   flush                 one-cycle request to empty the FIFO
//   err_clear             one-cycle request to zero the counters and overrun
//   rx_data               receiver byte, stable while rx_valid is high
//   rx_valid/ferror/perror receiver status levels, asynchronous to clk
//   rx_en                 receiver enable, high only in RUN
//   fifo_data             head byte (8'h00 while the FIFO is empty)
//   fifo_valid/fifo_ready consumer handshake: a byte pops on a cycle where
//                         both are high; fifo_data is stable while fifo_valid
//                         is high and fifo_ready is low
//   fifo_count            occupancy, 0..FIFO_DEPTH
//   overrun               sticky, a byte was dropped on a full FIFO
//   ferror_count          saturating framing-error count
//   perror_count          saturating parity-error count
//   state                 FSM state: IDLE=00 RUN=01 DRAIN=10 FLUSH=11
// -----------------------------------------------------------------------------
module uart_rx_controller #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 3,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ctrl_enable,
    input  logic                 flush,
    input  logic                 err_clear,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    input  logic                 rx_ferror,
    input  logic                 rx_perror,
    output logic                 rx_en,
    output logic [7:0]           fifo_data,
    output logic                 fifo_valid,
    input  logic                 fifo_ready,
    output logic [ADDR_W:0]      fifo_count,
    output logic                 overrun,
    output logic [ERR_CNT_W-1:0] ferror_count,
    output logic [ERR_CNT_W-1:0] perror_count,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_FLUSH = 2'b11
    } state_t;

    // Bit order in the synchroniser vectors: [0]=valid, [1]=ferror, [2]=perror.
    // Each bit is an independent level, so a plain per-bit 2-flop chain is safe.
    logic [2:0] s1_q, s1_d;
    logic [2:0] s2_q, s2_d;
    logic [2:0] s3_q, s3_d;

    state_t                state_q, state_d;
    logic [7:0]            mem_q [FIFO_DEPTH];
    logic [7:0]            mem_d [FIFO_DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]       count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic [ERR_CNT_W-1:0]  ferr_cnt_q, ferr_cnt_d;
    logic [ERR_CNT_W-1:0]  perr_cnt_q, perr_cnt_d;

    logic [2:0] evt;
    logic       valid_evt;
    logic       ferr_evt;
    logic       perr_evt;
    logic       flush_take;
    logic       push_evt;
    logic       pop;
    logic       full;
    logic       push_ok;
    logic       drop;

    // Rising edge of each synchronised level. The chain runs in every state so
    // a level still held from before a re-enable has already been consumed.
    assign evt       = s2_q & ~s3_q;
    assign valid_evt = evt[0];
    assign ferr_evt  = evt[1];
    assign perr_evt  = evt[2];

    assign fifo_valid = (count_q != '0);
    assign pop        = fifo_valid & fifo_ready;
    assign full       = (count_q == (ADDR_W+1)'(FIFO_DEPTH));
    assign flush_take = flush && (state_q != ST_FLUSH);
    assign push_evt   = valid_evt && (state_q == ST_RUN);
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    assign push_ok    = push_evt && !flush_take && (!full || pop);
    // Flush silently discards a coincident push; it is not an overrun.
    assign drop       = push_evt && !flush_take && full && !pop;

    always_comb begin
        s1_d = {rx_perror, rx_ferror, rx_valid};
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (flush)            state_d = ST_FLUSH;
                else if (ctrl_enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (flush)             state_d = ST_FLUSH;
                else if (!ctrl_enable) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (flush)                state_d = ST_FLUSH;
                else if (ctrl_enable)     state_d = ST_RUN;
                else if (count_q == '0)   state_d = ST_IDLE;
            end
            ST_FLUSH: begin
                state_d = ctrl_enable ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO storage, pointers and occupancy. The flush clears the FIFO on the
    // edge where it is accepted, so the FLUSH cycle already shows it empty; a
    // pop on that same edge has been handed out from the old head.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_take) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = rx_data;
                wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_d = count_q + (ADDR_W+1)'(1);
                2'b01:   count_d = count_q - (ADDR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Error counters and overrun; a clear wins over a same-cycle update.
    always_comb begin
        ferr_cnt_d = ferr_cnt_q;
        perr_cnt_d = perr_cnt_q;
        overrun_d  = overrun_q;
        if (err_clear) begin
            ferr_cnt_d = '0;
            perr_cnt_d = '0;
            overrun_d  = 1'b0;
        end else begin
            if (ferr_evt && (ferr_cnt_q != '1)) ferr_cnt_d = ferr_cnt_q + ERR_CNT_W'(1);
            if (perr_evt && (perr_cnt_q != '1)) perr_cnt_d = perr_cnt_q + ERR_CNT_W'(1);
            if (drop)                           overrun_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            ferr_cnt_q <= '0;
            perr_cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            ferr_cnt_q <= ferr_cnt_d;
            perr_cnt_q <= perr_cnt_d;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign rx_en        = (state_q == ST_RUN);
    assign fifo_data    = fifo_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count   = count_q;
    assign overrun      = overrun_q;
    assign ferror_count = ferr_cnt_q;
    assign perror_count = perr_cnt_q;
    assign state        = state_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_controller
//
// Directed bench for uart_rx_controller. Inputs change 1 ns after a rising
// clock edge and outputs are sampled at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_controller;

    logic       clk;
    logic       reset;
    logic       ctrl_enable;
    logic       flush;
    logic       err_clear;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferror;
    logic       rx_perror;
    logic       rx_en;
    logic [7:0] fifo_data;
    logic       fifo_valid;
    logic       fifo_ready;
    logic [3:0] fifo_count;
    logic       overrun;
    logic [7:0] ferror_count;
    logic [7:0] perror_count;
    logic [1:0] state;

    int checks;
    int errors;

    uart_rx_controller #(
        .FIFO_DEPTH(8),
        .ADDR_W    (3),
        .ERR_CNT_W (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ctrl_enable (ctrl_enable),
        .flush       (flush),
        .err_clear   (err_clear),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ferror   (rx_ferror),
        .rx_perror   (rx_perror),
        .rx_en       (rx_en),
        .fifo_data   (fifo_data),
        .fifo_valid  (fifo_valid),
        .fifo_ready  (fifo_ready),
        .fifo_count  (fifo_count),
        .overrun     (overrun),
        .ferror_count(ferror_count),
        .perror_count(perror_count),
        .state       (state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overall time limit
    initial begin
        #1000000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One receiver frame: levels held high for 4 clocks, then low for 4.
    task automatic rx_frame(input logic [7:0] b, input logic v, input logic fe, input logic pe);
        rx_data   = b;
        rx_valid  = v;
        rx_ferror = fe;
        rx_perror = pe;
        repeat (4) step();
        rx_valid  = 1'b0;
        rx_ferror = 1'b0;
        rx_perror = 1'b0;
        repeat (4) step();
    endtask

    task automatic pulse_err_clear();
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        ctrl_enable = 1'b0;
        flush       = 1'b0;
        err_clear   = 1'b0;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        rx_ferror   = 1'b0;
        rx_perror   = 1'b0;
        fifo_ready  = 1'b0;
        repeat (2) step();

        // Reset values
        check_eq("rst_state", state, 2'b00);
        check_eq("rst_rx_en", rx_en, 1'b0);
        check_eq("rst_count", fifo_count, 4'd0);
        check_eq("rst_valid", fifo_valid, 1'b0);
        check_eq("rst_data", fifo_data, 8'h00);
        check_eq("rst_overrun", overrun, 1'b0);
        check_eq("rst_ferr", ferror_count, 8'd0);
        check_eq("rst_perr", perror_count, 8'd0);
        reset = 1'b0;
        step();

        // 1: enable, A5 then 3C, latency and handshake
        ctrl_enable = 1'b1;
        step();
        check_eq("t1_state_run", state, 2'b01);
        check_eq("t1_rx_en", rx_en, 1'b1);
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        step();
        check_eq("t1_lat_e1", fifo_valid, 1'b0);
        step();
        check_eq("t1_lat_e2", fifo_valid, 1'b0);
        step();
        check_eq("t1_lat_e3", fifo_valid, 1'b1);
        check_eq("t1_first_data", fifo_data, 8'hA5);
        step();
        rx_valid = 1'b0;
        repeat (4) step();
        rx_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        check_eq("t1_count2", fifo_count, 4'd2);
        check_eq("t1_head_a5", fifo_data, 8'hA5);
        fifo_ready = 1'b1;
        step();
        check_eq("t1_head_3c", fifo_data, 8'h3C);
        step();
        check_eq("t1_empty", fifo_valid, 1'b0);
        check_eq("t1_empty_data", fifo_data, 8'h00);
        fifo_ready = 1'b0;

        // 2: nine bytes into eight entries
        for (int i = 1; i <= 9; i++) rx_frame(8'(i), 1'b1, 1'b0, 1'b0);
        check_eq("t2_count_full", fifo_count, 4'd8);
        check_eq("t2_overrun", overrun, 1'b1);
        fifo_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check_eq($sformatf("t2_read_%0d", i), fifo_data, 32'(i));
            step();
        end
        check_eq("t2_ninth_lost", fifo_valid, 1'b0);
        check_eq("t2_count0", fifo_count, 4'd0);
        fifo_ready = 1'b0;
        pulse_err_clear();
        check_eq("t2_overrun_clr", overrun, 1'b0);

        // 3: push into a full FIFO while the head is popped
        for (int i = 0; i < 8; i++) rx_frame(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
        check_eq("t3_count_full", fifo_count, 4'd8);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        repeat (2) step();
        check_eq("t3_head_10", fifo_data, 8'h10);
        fifo_ready = 1'b1;
        step();
        fifo_ready = 1'b0;
        check_eq("t3_count_held", fifo_count, 4'd8);
        check_eq("t3_no_overrun", overrun, 1'b0);
        repeat (2) step();
        rx_valid = 1'b0;
        repeat (4) step();
        fifo_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check_eq($sformatf("t3_read_%0d", i), fifo_data, 32'h11 + 32'(i));
            step();
        end
        check_eq("t3_read_55_last", fifo_data, 8'h55);
        step();
        check_eq("t3_empty", fifo_valid, 1'b0);
        fifo_ready = 1'b0;

        // 4: error counters and saturation
        for (int i = 0; i < 3; i++) rx_frame(8'h00, 1'b0, 1'b1, 1'b0);
        check_eq("t4_ferr3", ferror_count, 8'd3);
        for (int i = 0; i < 255; i++) rx_frame(8'h00, 1'b0, 1'b0, 1'b1);
        check_eq("t4_perr255", perror_count, 8'hFF);
        for (int i = 0; i < 5; i++) rx_frame(8'h00, 1'b0, 1'b0, 1'b1);
        check_eq("t4_perr_sat", perror_count, 8'hFF);
        check_eq("t4_ferr_still3", ferror_count, 8'd3);
        check_eq("t4_no_push", fifo_count, 4'd0);
        pulse_err_clear();
        check_eq("t4_ferr_clr", ferror_count, 8'd0);
        check_eq("t4_perr_clr", perror_count, 8'd0);

        // 5: drain then re-enable with rx_valid held high
        for (int i = 0; i < 4; i++) rx_frame(8'h21 + 8'(i), 1'b1, 1'b0, 1'b0);
        check_eq("t5_count4", fifo_count, 4'd4);
        ctrl_enable = 1'b0;
        step();
        check_eq("t5_state_drain", state, 2'b10);
        check_eq("t5_rx_en_off", rx_en, 1'b0);
        fifo_ready = 1'b1;
        repeat (4) step();
        fifo_ready = 1'b0;
        check_eq("t5_drained", fifo_count, 4'd0);
        check_eq("t5_still_drain", state, 2'b10);
        step();
        check_eq("t5_state_idle", state, 2'b00);
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        repeat (4) step();
        ctrl_enable = 1'b1;
        repeat (6) step();
        check_eq("t5_state_run", state, 2'b01);
        check_eq("t5_no_spurious", fifo_count, 4'd0);
        rx_valid = 1'b0;
        repeat (4) step();

        // 6: flush with a coincident push, then async reset mid-frame
        for (int i = 0; i < 5; i++) rx_frame(8'h31 + 8'(i), 1'b1, 1'b0, 1'b0);
        rx_frame(8'h00, 1'b0, 1'b1, 1'b0);
        check_eq("t6_count5", fifo_count, 4'd5);
        check_eq("t6_ferr1", ferror_count, 8'd1);
        rx_data  = 8'h66;
        rx_valid = 1'b1;
        repeat (2) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("t6_state_flush", state, 2'b11);
        check_eq("t6_flush_count", fifo_count, 4'd0);
        check_eq("t6_flush_valid", fifo_valid, 1'b0);
        check_eq("t6_flush_data", fifo_data, 8'h00);
        check_eq("t6_flush_overrun", overrun, 1'b0);
        check_eq("t6_flush_ferr", ferror_count, 8'd1);
        step();
        check_eq("t6_state_run", state, 2'b01);
        check_eq("t6_byte_dropped", fifo_count, 4'd0);
        rx_valid = 1'b0;
        repeat (4) step();
        rx_frame(8'h44, 1'b1, 1'b0, 1'b0);
        check_eq("t6_count1", fifo_count, 4'd1);
        rx_data  = 8'h45;
        rx_valid = 1'b1;
        step();
        #2;
        reset = 1'b1;
        #1;
        check_eq("t6_ar_state", state, 2'b00);
        check_eq("t6_ar_rx_en", rx_en, 1'b0);
        check_eq("t6_ar_count", fifo_count, 4'd0);
        check_eq("t6_ar_valid", fifo_valid, 1'b0);
        check_eq("t6_ar_data", fifo_data, 8'h00);
        check_eq("t6_ar_overrun", overrun, 1'b0);
        check_eq("t6_ar_ferr", ferror_count, 8'd0);
        check_eq("t6_ar_perr", perror_count, 8'd0);
        rx_valid    = 1'b0;
        ctrl_enable = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
